// File: rtl/tmr_mon_pkg.sv
// Shared types and defaults for the TMR error monitor.
// Holds the IRQ state encoding and the readout-select width helper.
package tmr_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    ACKED
  } irq_state_t;

  localparam int N_SRC_DEF  = 4;
  localparam int CNT_W_DEF  = 8;
  localparam int FILTER_DEF = 2;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tmr_err_chan.sv
// One monitored source: glitch filter with re-arm, saturating event counter
// and sticky flag.
module tmr_err_chan #(
  parameter int CNT_W  = 8,
  parameter int FILTER = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             err_q,
  input  logic             clr,
  output logic             evt,
  output logic [CNT_W-1:0] cnt,
  output logic             sticky,
  output logic             sat
);

  localparam int RUN_W = $clog2(FILTER + 1);

  logic [RUN_W-1:0] run;
  logic             armed;

  // Fires while the run is about to reach FILTER, so the count lands on that edge.
  assign evt = err_q && armed && (run == RUN_W'(FILTER - 1));
  assign sat = (cnt == {CNT_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= '0;
      armed <= 1'b1;
    end else if (!err_q) begin
      run   <= '0;
      armed <= 1'b1;
    end else begin
      if (run != RUN_W'(FILTER)) run <= run + RUN_W'(1);
      if (evt) armed <= 1'b0;
    end
  end

  // clr wins over a coincident event; the filter keeps running so the episode won't re-fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      sticky <= 1'b0;
    end else if (clr) begin
      cnt    <= '0;
      sticky <= 1'b0;
    end else if (evt) begin
      if (!sat) cnt <= cnt + CNT_W'(1);
      sticky <= 1'b1;
    end
  end

endmodule

// File: rtl/tmr_err_monitor.sv
// Consumer of the TMR error-sink outputs: filters glitches, counts events per
// source and raises one level interrupt with an acknowledge handshake.
module tmr_err_monitor
  import tmr_mon_pkg::*;
#(
  parameter int N_SRC  = N_SRC_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int FILTER = FILTER_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_SRC-1:0]              err_in,
  input  logic                          clr,
  input  logic [sel_width(N_SRC)-1:0]   rd_sel,
  output logic [CNT_W-1:0]              rd_cnt,
  output logic [N_SRC-1:0]              sticky,
  output logic [N_SRC-1:0]              sat,
  output logic                          irq,
  input  logic                          irq_ack
);

  logic [N_SRC-1:0] err_q;
  logic [N_SRC-1:0] evt;
  logic [CNT_W-1:0] cnt [N_SRC];
  logic             any_evt;
  logic             missed;
  irq_state_t       state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_in;
  end

  for (genvar i = 0; i < N_SRC; i++) begin : g_chan
    tmr_err_chan #(
      .CNT_W  (CNT_W),
      .FILTER (FILTER)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .err_q  (err_q[i]),
      .clr    (clr),
      .evt    (evt[i]),
      .cnt    (cnt[i]),
      .sticky (sticky[i]),
      .sat    (sat[i])
    );
  end

  assign any_evt = (|evt) && !clr;

  always_comb begin
    rd_cnt = '0;
    if (int'(rd_sel) < N_SRC) rd_cnt = cnt[rd_sel];
  end

  // Events seen while acknowledged are remembered so they re-raise irq once ack drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      irq    <= 1'b0;
      missed <= 1'b0;
    end else if (clr) begin
      state  <= IDLE;
      irq    <= 1'b0;
      missed <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_evt) begin
            state <= PEND;
            irq   <= 1'b1;
          end
        end
        PEND: begin
          if (irq_ack) begin
            state <= ACKED;
            irq   <= 1'b0;
          end
        end
        ACKED: begin
          if (!irq_ack) begin
            state  <= (missed || any_evt) ? PEND : IDLE;
            irq    <= missed || any_evt;
            missed <= 1'b0;
          end else if (any_evt) begin
            missed <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          irq    <= 1'b0;
          missed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmr_err_monitor.sv
// Self-checking bench for tmr_err_monitor: directed scenarios plus random
// traffic, compared against an episode-length based reference model.
module tb_tmr_err_monitor;

  localparam int N      = 4;
  localparam int CW     = 4;
  localparam int FILT   = 2;
  localparam int CMAX   = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  err_in;
  logic          clr;
  logic [1:0]    rd_sel;
  logic [CW-1:0] rd_cnt;
  logic [N-1:0]  sticky;
  logic [N-1:0]  sat;
  logic          irq;
  logic          irq_ack;

  int tests = 0;
  int fails = 0;

  // Reference model state: episode lengths seen on err_in, pending events, counts.
  int   m_len   [N];
  bit   m_pend  [N];
  int   m_cnt   [N];
  bit   m_sticky[N];
  bit   m_irq, m_acked, m_missed;

  tmr_err_monitor #(
    .N_SRC  (N),
    .CNT_W  (CW),
    .FILTER (FILT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .err_in  (err_in),
    .clr     (clr),
    .rd_sel  (rd_sel),
    .rd_cnt  (rd_cnt),
    .sticky  (sticky),
    .sat     (sat),
    .irq     (irq),
    .irq_ack (irq_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      m_len[i] = 0; m_pend[i] = 0; m_cnt[i] = 0; m_sticky[i] = 0;
    end
    m_irq = 0; m_acked = 0; m_missed = 0;
  endtask

  // An event is an episode reaching FILT consecutive high samples; it shows one edge later.
  task automatic modelEdge();
    bit any;
    if (!rst_n) begin
      modelReset();
      return;
    end
    if (clr) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 0; m_sticky[i] = 0;
      end
      m_irq = 0; m_acked = 0; m_missed = 0;
    end else begin
      any = 0;
      for (int i = 0; i < N; i++) begin
        if (m_pend[i]) begin
          any = 1;
          m_sticky[i] = 1;
          if (m_cnt[i] < CMAX) m_cnt[i]++;
        end
      end
      if (m_acked) begin
        if (!irq_ack) begin
          m_irq = m_missed || any;
          m_acked = 0; m_missed = 0;
        end else if (any) begin
          m_missed = 1;
        end
      end else if (m_irq) begin
        if (irq_ack) begin
          m_irq = 0; m_acked = 1;
        end
      end else if (any) begin
        m_irq = 1;
      end
    end
    for (int i = 0; i < N; i++) begin
      m_len[i]  = err_in[i] ? m_len[i] + 1 : 0;
      m_pend[i] = (m_len[i] == FILT);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] e, input logic c, input logic a);
    err_in  = e;
    clr     = c;
    irq_ack = a;
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkOutput();
    logic [N-1:0] expSticky, expSat;
    for (int s = 0; s < N; s++) begin
      rd_sel = 2'(s);
      #1;
      check($sformatf("rd_cnt[%0d]", s), 32'(rd_cnt), 32'(m_cnt[s]));
      expSticky[s] = m_sticky[s];
      expSat[s]    = (m_cnt[s] == CMAX);
    end
    check("sticky", 32'(sticky), 32'(expSticky));
    check("sat",    32'(sat),    32'(expSat));
    check("irq",    32'(irq),    32'(m_irq));
  endtask

  task automatic step(input logic [N-1:0] e, input logic c, input logic a);
    applyStimulus(e, c, a);
    checkOutput();
  endtask

  task automatic pulse(input logic [N-1:0] e, input logic a);
    step(e, 1'b0, a);
    step(e, 1'b0, a);
    step('0, 1'b0, a);
  endtask

  initial begin
    logic [N-1:0] re;
    logic         ra;
    rst_n = 1'b0; err_in = '0; clr = 1'b0; irq_ack = 1'b0; rd_sel = '0;
    modelReset();
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Glitch rejection, then a qualifying 2-cycle episode
    step(4'b0001, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    pulse(4'b0001, 1'b0);
    step('0, 1'b0, 1'b0);

    // Long episode counts once, a second short one counts again
    for (int k = 0; k < 50; k++) step(4'b0010, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(4'b0010, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);

    // Saturation on source 2, then clear
    for (int k = 0; k < 20; k++) pulse(4'b0100, 1'b0);
    step('0, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0);

    // Handshake: ack, missed event while acked, plain ack/release
    pulse(4'b0001, 1'b0);
    step('0, 1'b0, 1'b1);
    pulse(4'b1000, 1'b1);
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1);

    // clr coincident with a qualifying event; held episode must not re-fire
    step('0, 1'b1, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) step(4'b0001, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    pulse(4'b0001, 1'b0);

    // Build counts 5/3/0/1 with irq pending, then async reset between edges
    step('0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++)
      pulse(4'b0001 | (k < 3 ? 4'b0010 : 4'b0000) | (k < 1 ? 4'b1000 : 4'b0000), 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    rst_n = 1'b0;
    modelReset();
    checkOutput();
    step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    rst_n = 1'b1;
    step('0, 1'b0, 1'b0);
    pulse(4'b0110, 1'b0);

    // All sources held high permanently count exactly once each
    step('0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) step(4'b1111, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);

    // Random traffic with occasional ack toggles and rare clears
    re = '0;
    ra = 1'b0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 2) == 0) re[i] = ~re[i];
      if ($urandom_range(0, 4) == 0) ra = ~ra;
      step(re, ($urandom_range(0, 49) == 0), ra);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
